// File: rtl/bsg_mem_1rw_sync_mask_write_byte_subbanked_fe.sv
// Ready/valid front end for a subbanked byte-masked 1RW sync SRAM with a credit-limited response FIFO.
// Optional: define BSG_MEM_SUBBANKED_FE_ZERO_UNREAD_EN to store non-enabled subbanks of a read as zero.
module bsg_mem_1rw_sync_mask_write_byte_subbanked_fe #(
  parameter int width_p       = 64,
  parameter int els_p         = 16,
  parameter int num_subbank_p = 2,
  parameter int fifo_els_p    = 2,
  localparam int subbank_width_lp = width_p / num_subbank_p,
  localparam int mask_width_lp    = subbank_width_lp / 8,
  localparam int lg_els_lp        = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,

  input  logic                                    v_i,
  output logic                                    ready_and_o,
  input  logic                                    w_i,
  input  logic [num_subbank_p-1:0]                subbank_v_i,
  input  logic [num_subbank_p*mask_width_lp-1:0]  w_mask_i,
  input  logic [width_p-1:0]                      data_i,
  input  logic [lg_els_lp-1:0]                    addr_i,

  output logic [num_subbank_p-1:0]                sram_v_o,
  output logic                                    sram_w_o,
  output logic [lg_els_lp-1:0]                    sram_addr_o,
  output logic [num_subbank_p*mask_width_lp-1:0]  sram_w_mask_o,
  output logic [width_p-1:0]                      sram_data_o,
  input  logic [width_p-1:0]                      sram_data_i,

  output logic                                    v_o,
  output logic [width_p-1:0]                      data_o,
  input  logic                                    yumi_i
);

  // Handshakes: a request transfers when v_i & ready_and_o in the same cycle;
  // a response transfers when v_o & yumi_i. ready_and_o is a function of
  // registered state and reset only, and yumi_i is ignored while v_o is low.

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp   = ptr_w_lp'(fifo_els_p - 1);
  localparam logic [cnt_w_lp:0]   credit_lim_lp = (cnt_w_lp + 1)'(fifo_els_p);

  logic                 inflight_r;
  logic [cnt_w_lp-1:0]  count_r;
  logic [ptr_w_lp-1:0]  rd_ptr_r;
  logic [ptr_w_lp-1:0]  wr_ptr_r;
  logic [width_p-1:0]   fifo_mem_r [fifo_els_p];

  logic                 accept;
  logic                 rd_issue;
  logic                 push;
  logic                 pop;
  logic [cnt_w_lp:0]    used;
  logic [width_p-1:0]   push_data;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Credits cover both stored responses and the read whose data arrives next cycle.
  assign used        = {1'b0, count_r} + (cnt_w_lp + 1)'(inflight_r);
  assign ready_and_o = reset_n_i & (used < credit_lim_lp);

  assign accept   = v_i & ready_and_o;
  assign rd_issue = accept & ~w_i & (|subbank_v_i);
  assign push     = inflight_r;
  assign pop      = yumi_i & v_o;

  assign sram_v_o    = subbank_v_i & {num_subbank_p{accept}};
  assign sram_w_o    = w_i;
  assign sram_addr_o = addr_i;
  assign sram_data_o = data_i;

  for (genvar s = 0; s < num_subbank_p; s++) begin : g_mask
    assign sram_w_mask_o[s*mask_width_lp +: mask_width_lp] =
      w_mask_i[s*mask_width_lp +: mask_width_lp] & {mask_width_lp{subbank_v_i[s]}};
  end

`ifdef BSG_MEM_SUBBANKED_FE_ZERO_UNREAD_EN
  logic [num_subbank_p-1:0] rd_sub_v_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rd_sub_v_r <= '0;
    else            rd_sub_v_r <= subbank_v_i;
  end

  for (genvar s = 0; s < num_subbank_p; s++) begin : g_zero
    assign push_data[s*subbank_width_lp +: subbank_width_lp] = rd_sub_v_r[s]
      ? sram_data_i[s*subbank_width_lp +: subbank_width_lp]
      : '0;
  end
`else
  assign push_data = sram_data_i;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      inflight_r <= 1'b0;
      count_r    <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
    end else begin
      inflight_r <= rd_issue;
      if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (push && !pop)      count_r <= count_r + cnt_w_lp'(1);
      else if (!push && pop) count_r <= count_r - cnt_w_lp'(1);
    end
  end

  // Storage carries no reset; only occupancy and pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_r[wr_ptr_r] <= push_data;
  end

  assign v_o    = (count_r != '0);
  assign data_o = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_subbanked_fe.sv
// Table-driven bench for the subbanked SRAM front end, with a behavioural SRAM and hand-written corner sequences.
module tb_bsg_mem_1rw_sync_mask_write_byte_subbanked_fe;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_and_o;
  logic        w_i;
  logic [1:0]  subbank_v_i;
  logic [7:0]  w_mask_i;
  logic [63:0] data_i;
  logic [3:0]  addr_i;
  logic [1:0]  sram_v_o;
  logic        sram_w_o;
  logic [3:0]  sram_addr_o;
  logic [7:0]  sram_w_mask_o;
  logic [63:0] sram_data_o;
  logic [63:0] sram_data_i;
  logic        v_o;
  logic [63:0] data_o;
  logic        yumi_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  bsg_mem_1rw_sync_mask_write_byte_subbanked_fe #(
    .width_p(64), .els_p(16), .num_subbank_p(2), .fifo_els_p(2)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .v_i(v_i), .ready_and_o(ready_and_o), .w_i(w_i),
    .subbank_v_i(subbank_v_i), .w_mask_i(w_mask_i), .data_i(data_i), .addr_i(addr_i),
    .sram_v_o(sram_v_o), .sram_w_o(sram_w_o), .sram_addr_o(sram_addr_o),
    .sram_w_mask_o(sram_w_mask_o), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  function automatic logic [63:0] pat(input int a);
    return 64'hA5A5_0000_5A5A_0000 | (64'(a) << 32) | 64'(a);
  endfunction

  // Behavioural byte-masked SRAM: read data appears the cycle after the read.
  logic [63:0] sram_mem [16];
  always @(posedge clk_i) begin
    sram_data_i <= 64'hDEAD_BEEF_DEAD_BEEF;
    if (!reset_n_i) begin
      for (int i = 0; i < 16; i++) sram_mem[i] <= pat(i);
    end else if (|sram_v_o) begin
      if (sram_w_o) begin
        for (int b = 0; b < 8; b++)
          if (sram_v_o[b/4] && sram_w_mask_o[b])
            sram_mem[sram_addr_o][b*8 +: 8] <= sram_data_o[b*8 +: 8];
      end else begin
        sram_data_i <= sram_mem[sram_addr_o];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_n_i && yumi_i && !v_o) begin
      checks++;
      errors++;
      $display("FAIL illegal_yumi: yumi_i=1 while v_o=%b", v_o);
    end
  end

  typedef struct {
    logic        v;
    logic        w;
    logic [1:0]  sub;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [3:0]  addr;
    logic        yumi;
    logic        er;
    logic [1:0]  esv;
    logic [7:0]  emask;
    logic        ev;
    logic        cd;
    logic [63:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic w, input logic [1:0] sub, input logic [7:0] mask,
                     input logic [63:0] data, input logic [3:0] addr, input logic yumi,
                     input logic er, input logic [1:0] esv, input logic [7:0] emask,
                     input logic ev, input logic cd, input logic [63:0] ed);
    vec_t t;
    t.v = v; t.w = w; t.sub = sub; t.mask = mask; t.data = data; t.addr = addr; t.yumi = yumi;
    t.er = er; t.esv = esv; t.emask = emask; t.ev = ev; t.cd = cd; t.ed = ed;
    vecs.push_back(t);
  endtask

  task automatic idle();
    v_i = 1'b0; w_i = 1'b0; subbank_v_i = 2'b00; w_mask_i = 8'h00;
    data_i = 64'h0; addr_i = 4'h0; yumi_i = 1'b0;
  endtask

  logic [63:0] exp_q[$];
  logic [63:0] m3;
  logic [63:0] m9;
  logic [63:0] z5;

  initial begin
    idle();
    reset_n_i = 1'b0;
    v_i = 1'b1; subbank_v_i = 2'b11;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_ready", 64'(ready_and_o), 64'd0);
    chk("reset_v_o", 64'(v_o), 64'd0);
    chk("reset_sram_v", 64'(sram_v_o), 64'd0);
    idle();
    reset_n_i = 1'b1;
    #1;
    chk("release_ready", 64'(ready_and_o), 64'd1);

    // Full write, then low-subbank write with bytes 0..3 enabled.
    m3 = 64'h1122_3344_AAAA_AAAA;
    // High subbank takes 0x77777777; low subbank keeps its pattern because its mask is gated off.
    m9 = 64'h7777_7777_5A5A_0009;
`ifdef BSG_MEM_SUBBANKED_FE_ZERO_UNREAD_EN
    z5 = 64'hA5A5_0005_0000_0000;
`else
    z5 = pat(5);
`endif
    //  v  w  sub    mask   data                    addr yumi | rdy esv   emask  v_o chk data
    add(1, 1, 2'b11, 8'hFF, 64'h1122334455667788, 3, 0,  1, 2'b11, 8'hFF, 0, 0, 0);
    add(1, 1, 2'b01, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 3, 0,  1, 2'b01, 8'h0F, 0, 0, 0);
    add(1, 0, 2'b11, 8'h00, 64'h0, 3, 0,                 1, 2'b11, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 0,                 1, 2'b00, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 0,                 1, 2'b00, 8'h00, 1, 1, m3);
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 1,                 1, 2'b00, 8'h00, 1, 1, m3);
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 0,                 1, 2'b00, 8'h00, 0, 0, 0);
    add(1, 0, 2'b00, 8'h00, 64'h0, 1, 0,                 1, 2'b00, 8'h00, 0, 0, 0);
    add(1, 1, 2'b10, 8'hFF, 64'h7777777712345678, 9, 0,  1, 2'b10, 8'hF0, 0, 0, 0);
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 0,                 1, 2'b00, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 0,                 1, 2'b00, 8'h00, 0, 0, 0);
    add(1, 0, 2'b11, 8'h00, 64'h0, 9, 0,                 1, 2'b11, 8'h00, 0, 0, 0);
    add(1, 0, 2'b11, 8'h00, 64'h0, 4, 0,                 1, 2'b11, 8'h00, 0, 0, 0);
    add(1, 0, 2'b11, 8'h00, 64'h0, 6, 0,                 0, 2'b00, 8'h00, 1, 1, m9);
    add(1, 0, 2'b11, 8'h00, 64'h0, 6, 0,                 0, 2'b00, 8'h00, 1, 1, m9);
    add(1, 0, 2'b11, 8'h00, 64'h0, 6, 1,                 0, 2'b00, 8'h00, 1, 1, m9);
    add(1, 0, 2'b11, 8'h00, 64'h0, 6, 0,                 1, 2'b11, 8'h00, 1, 1, pat(4));
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 1,                 0, 2'b00, 8'h00, 1, 1, pat(4));
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 0,                 1, 2'b00, 8'h00, 1, 1, pat(6));
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 1,                 1, 2'b00, 8'h00, 1, 1, pat(6));
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 0,                 1, 2'b00, 8'h00, 0, 0, 0);
    add(1, 0, 2'b10, 8'h00, 64'h0, 5, 0,                 1, 2'b10, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 0,                 1, 2'b00, 8'h00, 0, 0, 0);
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 1,                 1, 2'b00, 8'h00, 1, 1, z5);
    add(0, 0, 2'b00, 8'h00, 64'h0, 0, 0,                 1, 2'b00, 8'h00, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk_i); #1;
      v_i = vecs[i].v; w_i = vecs[i].w; subbank_v_i = vecs[i].sub; w_mask_i = vecs[i].mask;
      data_i = vecs[i].data; addr_i = vecs[i].addr; yumi_i = vecs[i].yumi;
      @(negedge clk_i);
      chk($sformatf("vec%0d_ready", i), 64'(ready_and_o), 64'(vecs[i].er));
      chk($sformatf("vec%0d_sram_v", i), 64'(sram_v_o), 64'(vecs[i].esv));
      chk($sformatf("vec%0d_sram_mask", i), 64'(sram_w_mask_o), 64'(vecs[i].emask));
      chk($sformatf("vec%0d_v_o", i), 64'(v_o), 64'(vecs[i].ev));
      if (vecs[i].cd) chk($sformatf("vec%0d_data", i), data_o, vecs[i].ed);
    end

    // Reset asserted while a read's data is on its way back.
    @(posedge clk_i); #1;
    idle();
    v_i = 1'b1; subbank_v_i = 2'b11; addr_i = 4'd5;
    @(negedge clk_i);
    chk("midrd_ready", 64'(ready_and_o), 64'd1);
    chk("midrd_sram_v", 64'(sram_v_o), 64'd3);
    @(posedge clk_i); #1;
    reset_n_i = 1'b0;
    #1;
    chk("midrd_rst_v_o", 64'(v_o), 64'd0);
    chk("midrd_rst_ready", 64'(ready_and_o), 64'd0);
    chk("midrd_rst_sram_v", 64'(sram_v_o), 64'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    idle();
    reset_n_i = 1'b1;
    #1;
    chk("midrd_rel_ready", 64'(ready_and_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk($sformatf("midrd_post%0d_v_o", k), 64'(v_o), 64'd0);
      chk($sformatf("midrd_post%0d_ready", k), 64'(ready_and_o), 64'd1);
    end

    // Stream reads 0..7 with yumi_i tied to v_o; ready must track outstanding credits.
    begin
      int issued;
      int got;
      int cyc;
      issued = 0; got = 0; cyc = 0;
      exp_q.delete();
      while (got < 8 && cyc < 100) begin
        @(posedge clk_i); #1;
        idle();
        v_i = (issued < 8);
        subbank_v_i = 2'b11;
        addr_i = 4'(issued);
        yumi_i = v_o;
        @(negedge clk_i);
        chk($sformatf("stream_c%0d_ready", cyc), 64'(ready_and_o), 64'(exp_q.size() < 2));
        if (yumi_i) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL stream_c%0d_extra: response with nothing outstanding, data %h", cyc, data_o);
          end else begin
            chk($sformatf("stream_c%0d_data", cyc), data_o, exp_q.pop_front());
          end
          got++;
        end
        if (v_i && ready_and_o) begin
          exp_q.push_back(sram_mem[addr_i]);
          issued++;
        end
        cyc++;
      end
      chk("stream_responses", 64'(got), 64'd8);
      chk("stream_issued", 64'(issued), 64'd8);
      @(posedge clk_i); #1;
      idle();
      @(negedge clk_i);
      chk("stream_drained_v_o", 64'(v_o), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
